kgp_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the KGP-RISC datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the write enables of the DFF-based architectural state (PC, IR, flags, register file) and handshakes with the instruction and data memories. It sits between the instruction decoder (which supplies op_class) and the datapath registers/muxes, and detects HALT, illegal-op and memory-timeout faults.

---
 rtl/kgp_ctrl_pkg.sv | 16 +
 rtl/kgp_wait_timer.sv | 18 +
 rtl/kgp_multicycle_ctrl.sv | 91 +++++++++
 tb/tb_kgp_multicycle_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/kgp_ctrl_pkg.sv
// kgp_ctrl_pkg: sequencer state encoding, instruction class codes and default timeout
package kgp_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_FAULT
  } state_t;
  localparam logic [2:0] OP_ALU_R  = 3'd0;
  localparam logic [2:0] OP_ALU_I  = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_STORE  = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd5;
  localparam int DEF_TIMEOUT_CYC = 16;
  function automatic logic is_illegal(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction
endpackage

// File: rtl/kgp_wait_timer.sv
// kgp_wait_timer: memory wait counter; o_hit flags the last allowed wait cycle (TIMEOUT_CYC=0 never hits)
module kgp_wait_timer #(
  parameter int TIMEOUT_CYC = 16,
  parameter int TMR_W       = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);
  logic [TMR_W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + TMR_W'(1);
  assign o_hit = (TIMEOUT_CYC != 0) && (r_cnt == TMR_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/kgp_multicycle_ctrl.sv
// kgp_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving KGP-RISC state write enables
module kgp_multicycle_ctrl
  import kgp_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TMR_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op_class,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel_branch,
  output logic             flags_we,
  output logic             alu_src_imm,
  output logic             rf_we,
  output logic             wb_sel_mem,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);
  state_t           r_state;
  logic [2:0]       r_cls;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wait, w_hit, w_fetch_ok, w_br_take;
  // Timer runs only while a request is outstanding, so every entry to FETCH/MEM starts from zero
  assign w_wait = (r_state == ST_FETCH && !imem_ack) || (r_state == ST_MEM && !dmem_ack);
  kgp_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .TMR_W(TMR_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (!w_wait),
    .i_en  (w_wait),
    .o_hit (w_hit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_cls   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE:   if (start) r_state <= ST_FETCH;
        ST_FETCH:  if (imem_ack) r_state <= ST_DECODE; else if (w_hit) r_state <= ST_FAULT;
        ST_DECODE: begin
          r_cls   <= op_class;
          r_state <= op_class == OP_HALT ? ST_HALT : is_illegal(op_class) ? ST_FAULT : ST_EXEC;
        end
        ST_EXEC: begin
          r_state <= r_cls == OP_BRANCH ? ST_FETCH :
                     (r_cls == OP_LOAD || r_cls == OP_STORE) ? ST_MEM : ST_WB;
          if (r_cls == OP_BRANCH) r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_MEM:
          if (dmem_ack) begin
            r_state <= r_cls == OP_STORE ? ST_FETCH : ST_WB;
            if (r_cls == OP_STORE) r_cnt <= r_cnt + CNT_W'(1);
          end else if (w_hit) r_state <= ST_FAULT;
        ST_WB: begin
          r_state <= ST_FETCH;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        default: r_state <= r_state;
      endcase
    end
  assign w_fetch_ok    = r_state == ST_FETCH && imem_ack;
  assign w_br_take     = r_state == ST_EXEC && r_cls == OP_BRANCH && branch_taken;
  assign imem_req      = r_state == ST_FETCH;
  assign ir_we         = w_fetch_ok;
  assign pc_we         = w_fetch_ok || w_br_take;
  assign pc_sel_branch = w_br_take;
  assign flags_we      = r_state == ST_EXEC && (r_cls == OP_ALU_R || r_cls == OP_ALU_I);
  assign alu_src_imm   = r_state == ST_EXEC &&
                         (r_cls == OP_ALU_I || r_cls == OP_LOAD || r_cls == OP_STORE);
  assign dmem_req      = r_state == ST_MEM;
  assign dmem_we       = r_state == ST_MEM && r_cls == OP_STORE;
  assign rf_we         = r_state == ST_WB;
  assign wb_sel_mem    = r_state == ST_WB && r_cls == OP_LOAD;
  assign busy          = !(r_state == ST_IDLE || r_state == ST_HALT || r_state == ST_FAULT);
  assign halted        = r_state == ST_HALT;
  assign fault         = r_state == ST_FAULT;
  assign instr_count   = r_cnt;
endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// tb_kgp_multicycle_ctrl: directed steps push expected strobes/count to a scoreboard checked on falling edges
module tb_kgp_multicycle_ctrl;
  logic clk = 0, rst = 1, start = 0, branch_taken = 0, imem_ack = 0, dmem_ack = 0;
  logic [2:0] op_class = 0;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel_branch, flags_we;
  logic alu_src_imm, rf_we, wb_sel_mem, busy, halted, fault;
  logic [31:0] instr_count;
  logic [12:0] outs;
  int n_pass = 0, n_fail = 0, n_total = 0;
  localparam logic [12:0] IREQ = 13'h1000, DREQ = 13'h0800, DWE = 13'h0400, IRWE = 13'h0200;
  localparam logic [12:0] PCWE = 13'h0100, PCSEL = 13'h0080, FLG = 13'h0040, IMM = 13'h0020;
  localparam logic [12:0] RFWE = 13'h0010, WBM = 13'h0008, BUSY = 13'h0004, HLT = 13'h0002;
  localparam logic [12:0] FLT = 13'h0001;
  typedef struct { string tag; logic [12:0] exp; logic [31:0] cnt; } chk_t;
  chk_t q[$];
  always #5 clk = ~clk;
  kgp_multicycle_ctrl #(.CNT_W(32), .TIMEOUT_CYC(4), .TMR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op_class(op_class), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel_branch(pc_sel_branch),
    .flags_we(flags_we), .alu_src_imm(alu_src_imm), .rf_we(rf_we), .wb_sel_mem(wb_sel_mem),
    .busy(busy), .halted(halted), .fault(fault), .instr_count(instr_count)
  );
  assign outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel_branch, flags_we,
                 alu_src_imm, rf_we, wb_sel_mem, busy, halted, fault};
  always @(negedge clk)
    if (q.size() != 0) begin
      chk_t e;
      e = q.pop_front();
      n_total++;
      assert (outs === e.exp) n_pass++;
      else begin n_fail++; $error("FAIL %s outs got=%h want=%h", e.tag, outs, e.exp); end
      n_total++;
      assert (instr_count === e.cnt) n_pass++;
      else begin n_fail++; $error("FAIL %s_cnt got=%0d want=%0d", e.tag, instr_count, e.cnt); end
      n_total++;
      assert ($onehot0({rf_we, flags_we, dmem_req}) === 1'b1) n_pass++;
      else begin n_fail++; $error("FAIL %s_excl got=%b want=onehot0", e.tag, {rf_we, flags_we, dmem_req}); end
    end
  task automatic cyc(input logic s, input logic ia, input logic da, input logic bt,
                     input logic [2:0] oc, input logic [12:0] exp, input logic [31:0] cnt,
                     input string tag);
    @(posedge clk);
    #1;
    start = s; imem_ack = ia; dmem_ack = da; branch_taken = bt; op_class = oc;
    q.push_back('{tag, exp, cnt});
  endtask
  task automatic sync_rst();
    @(posedge clk);
    #1 rst = 1; start = 0; imem_ack = 0; dmem_ack = 0;
    @(posedge clk);
    #1 rst = 0;
  endtask
  initial begin
    @(posedge clk);
    #1 q.push_back('{"por", 13'h0, 32'd0});
    @(posedge clk);
    #1 rst = 0;
    cyc(0, 0, 0, 0, 0, 13'h0, 0, "idle");
    cyc(1, 0, 0, 0, 0, 13'h0, 0, "idle_start");
    cyc(0, 0, 0, 0, 0, IREQ | BUSY, 0, "alu_fetch_wait");
    cyc(0, 1, 0, 0, 0, IREQ | IRWE | PCWE | BUSY, 0, "alu_fetch_ack");
    cyc(0, 0, 0, 0, 0, BUSY, 0, "alu_decode");
    cyc(0, 0, 0, 0, 0, FLG | BUSY, 0, "alu_exec");
    cyc(0, 0, 0, 0, 0, RFWE | BUSY, 0, "alu_wb");
    cyc(0, 0, 0, 0, 0, IREQ | BUSY, 1, "ld_fetch_wait");
    cyc(0, 1, 0, 0, 0, IREQ | IRWE | PCWE | BUSY, 1, "ld_fetch_ack");
    cyc(0, 0, 0, 0, 2, BUSY, 1, "ld_decode");
    cyc(0, 0, 0, 0, 2, IMM | BUSY, 1, "ld_exec");
    cyc(0, 0, 0, 0, 2, DREQ | BUSY, 1, "ld_mem_w1");
    cyc(0, 0, 0, 0, 2, DREQ | BUSY, 1, "ld_mem_w2");
    cyc(0, 0, 0, 0, 2, DREQ | BUSY, 1, "ld_mem_w3");
    cyc(0, 0, 1, 0, 2, DREQ | BUSY, 1, "ld_mem_ack");
    cyc(0, 0, 0, 0, 2, RFWE | WBM | BUSY, 1, "ld_wb");
    cyc(0, 0, 0, 0, 3, IREQ | BUSY, 2, "st_fetch_wait");
    cyc(0, 1, 0, 0, 3, IREQ | IRWE | PCWE | BUSY, 2, "st_fetch_ack");
    cyc(0, 0, 0, 0, 3, BUSY, 2, "st_decode");
    cyc(0, 0, 0, 0, 3, IMM | BUSY, 2, "st_exec");
    cyc(0, 0, 0, 0, 3, DREQ | DWE | BUSY, 2, "st_mem_w1");
    cyc(0, 0, 1, 0, 3, DREQ | DWE | BUSY, 2, "st_mem_ack");
    cyc(0, 0, 0, 0, 4, IREQ | BUSY, 3, "bt_fetch_wait");
    cyc(0, 1, 0, 0, 4, IREQ | IRWE | PCWE | BUSY, 3, "bt_fetch_ack");
    cyc(0, 0, 0, 0, 4, BUSY, 3, "bt_decode");
    cyc(0, 0, 0, 1, 4, PCWE | PCSEL | BUSY, 3, "bt_exec_taken");
    cyc(0, 1, 0, 0, 4, IREQ | IRWE | PCWE | BUSY, 4, "bn_fetch_ack");
    cyc(0, 0, 0, 0, 4, BUSY, 4, "bn_decode");
    cyc(0, 0, 0, 0, 4, BUSY, 4, "bn_exec_not_taken");
    cyc(0, 0, 0, 0, 7, IREQ | BUSY, 5, "to_fetch_w1");
    cyc(0, 0, 0, 0, 7, IREQ | BUSY, 5, "to_fetch_w2");
    cyc(0, 0, 0, 0, 7, IREQ | BUSY, 5, "to_fetch_w3");
    cyc(0, 1, 0, 0, 7, IREQ | IRWE | PCWE | BUSY, 5, "to_ack_wins");
    cyc(0, 0, 0, 0, 7, BUSY, 5, "ill_decode");
    cyc(0, 0, 0, 0, 7, FLT, 5, "ill_fault");
    cyc(1, 1, 1, 0, 0, FLT, 5, "fault_start_ign");
    cyc(0, 0, 0, 0, 0, FLT, 5, "fault_sticky");
    sync_rst();
    cyc(1, 0, 0, 0, 0, 13'h0, 0, "rst_idle_start");
    cyc(0, 0, 0, 0, 0, IREQ | BUSY, 0, "tmo_w1");
    cyc(0, 0, 0, 0, 0, IREQ | BUSY, 0, "tmo_w2");
    cyc(0, 0, 0, 0, 0, IREQ | BUSY, 0, "tmo_w3");
    cyc(0, 0, 0, 0, 0, IREQ | BUSY, 0, "tmo_w4");
    cyc(0, 0, 0, 0, 0, FLT, 0, "tmo_fault");
    cyc(1, 0, 0, 0, 0, FLT, 0, "tmo_start_ign");
    sync_rst();
    cyc(1, 0, 0, 0, 0, 13'h0, 0, "a2_start");
    cyc(0, 1, 0, 0, 1, IREQ | IRWE | PCWE | BUSY, 0, "ai_fetch_ack");
    cyc(0, 0, 0, 0, 1, BUSY, 0, "ai_decode");
    cyc(0, 0, 0, 0, 1, FLG | IMM | BUSY, 0, "ai_exec");
    cyc(0, 0, 0, 0, 1, RFWE | BUSY, 0, "ai_wb");
    cyc(0, 0, 0, 0, 0, IREQ | BUSY, 1, "pre_rst_fetch");
    @(posedge clk);
    #1 start = 0; imem_ack = 0;
    #2 rst = 1;
    q.push_back('{"async_rst", 13'h0, 32'd0});
    @(posedge clk);
    #1 rst = 0;
    cyc(1, 0, 0, 0, 0, 13'h0, 0, "h_start");
    cyc(0, 1, 0, 0, 5, IREQ | IRWE | PCWE | BUSY, 0, "h_fetch_ack");
    cyc(0, 0, 0, 0, 5, BUSY, 0, "h_decode");
    cyc(1, 0, 0, 0, 5, HLT, 0, "h_halted");
    cyc(0, 0, 0, 0, 5, HLT, 0, "h_sticky");
    @(negedge clk);
    #1;
    n_total++;
    assert (q.size() === 0) n_pass++;
    else begin n_fail++; $error("FAIL drain got=%0d want=0", q.size()); end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
